// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: format select encoding and result entry layout.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_U     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_ZIMM  = 3'b110,
        IMM_UNDEF = 3'b111
    } imm_src_e;

    localparam int unsigned IMM_XLEN_DEF  = 32;
    localparam int unsigned IMM_TAG_W_DEF = 4;

    // Entry layout at the default widths; imm_gen rebuilds it at its own XLEN/TAG_W.
    typedef struct packed {
        logic [IMM_XLEN_DEF-1:0]  imm;
        logic [IMM_TAG_W_DEF-1:0] tag;
        logic                     illegal;
    } imm_entry_t;

    // Formats whose upper bits follow instr[31]; the rest are zero-extended.
    function automatic logic is_sext(input imm_src_e src);
        return src inside {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode and extension for RV32/RV64 (XLEN must be 32 or 64).
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  imm_src_e        imm_src_i,
    output logic [XLEN-1:0] imm_o
);

    logic        s;
    logic [31:0] raw;
    logic        unused_opcode;

    assign s             = instr_i[31];
    assign unused_opcode = ^instr_i[6:0];

    // raw is the 32-bit result; for RV64 only the top word needs extending.
    always_comb begin
        raw = '0;
        case (imm_src_i)
            IMM_I:     raw = {{20{s}}, instr_i[31:20]};
            IMM_S:     raw = {{20{s}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:     raw = {{19{s}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_J:     raw = {{11{s}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            IMM_U:     raw = {instr_i[31:12], 12'b0};
            IMM_SHAMT: raw = (XLEN == 64) ? {26'b0, instr_i[25:20]} : {27'b0, instr_i[24:20]};
            IMM_ZIMM:  raw = {27'b0, instr_i[19:15]};
            default:   raw = '0;
        endcase
    end

    if (XLEN == 64) begin : g_rv64
        assign imm_o = {{32{raw[31] & is_sext(imm_src_i)}}, raw};
    end else begin : g_rv32
        assign imm_o = raw;
    end

endmodule

// File: rtl/imm_gen.sv
// Pipelined immediate generator with a two-entry (output + skid) buffer.
// Optional IMM_GEN_ILLEGAL_CHK_EN adds a registered illegal flag for imm_src=111.
module imm_gen
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [2:0]       imm_src_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_ext_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             illegal_o
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
        logic             illegal;
`endif
    } entry_t;

    logic [1:0]      state_q, state_d;
    entry_t          out_q, out_d, skid_q, skid_d, new_entry;
    logic [XLEN-1:0] dec_imm;
    logic            accept, drain;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr_i  (instr_i),
        .imm_src_i(imm_src_e'(imm_src_i)),
        .imm_o    (dec_imm)
    );

    always_comb begin
        new_entry     = '0;
        new_entry.imm = dec_imm;
        new_entry.tag = tag_i;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
        new_entry.illegal = (imm_src_i == IMM_UNDEF);
`endif
    end

    assign accept = in_valid_i && (state_q != ST_FULL);
    assign drain  = out_ready_i && (state_q != ST_EMPTY);

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = new_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    out_d = new_entry;
                end else if (accept) begin
                    skid_d  = new_entry;
                    state_d = ST_FULL;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    // Both handshake outputs decode flops only, so out_ready_i never reaches in_ready_o.
    assign in_ready_o  = (state_q != ST_FULL);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign imm_ext_o   = out_q.imm;
    assign tag_o       = out_q.tag;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
    assign illegal_o   = out_q.illegal;
`else
    assign illegal_o   = 1'b0;
`endif

endmodule
